addsub_accumulator: RTL and testbench



---
 rtl/addsub_pkg.sv | 30 +++
 rtl/AddSub.sv | 32 +++
 rtl/addsub_accumulator.sv | 128 ++++++++++++
 tb/tb_addsub_accumulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the add/sub accumulator slice.
//   - state_t   : accumulator FSM states (ACCUM collects beats, HOLD presents
//                 the frame result)
//   - OP_ADD / OP_SUB : encoding of the in_sub / c0 operation select
//   - MAX_POS / MAX_NEG : two's-complement clamp limits for a given width,
//                 returned as 64-bit patterns; callers truncate to their width
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest positive value: 0111...1 in the low w bits.
    function automatic logic [63:0] MAX_POS(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value: 1000...0 in the low w bits.
    function automatic logic [63:0] MAX_NEG(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/AddSub.sv
// ---------------------------------------------------------------------------
// AddSub
// Combinational W-bit two's-complement adder/subtractor.
//   A   : in  W  first operand
//   B   : in  W  second operand
//   c0  : in  1  OP_SUB computes A - B, OP_ADD computes A + B
//   R   : out W  result, modulo 2^W
//   ovf : out 1  signed overflow of the operation
// ---------------------------------------------------------------------------
module AddSub
    import addsub_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         c0,
    output logic [W-1:0] R,
    output logic         ovf
);

    logic [W-1:0] b_eff;

    always_comb begin
        // Subtraction is A + ~B + 1; the carry-in supplies the +1.
        b_eff = (c0 == OP_SUB) ? ~B : B;
        R     = A + b_eff + {{(W-1){1'b0}}, c0};
        // Overflow: both effective operands share a sign the result lacks.
        ovf   = (A[W-1] == b_eff[W-1]) && (R[W-1] != A[W-1]);
    end

endmodule

// File: rtl/addsub_accumulator.sv
// ---------------------------------------------------------------------------
// addsub_accumulator
// Streaming frame accumulator built around one AddSub instance. Each accepted
// beat adds or subtracts in_data to/from the running sum; when the in_last
// beat is accepted the sum, sticky overflow and beat count are presented on a
// valid/ready output until taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. in_ready and out_valid depend only on the registered state, so
// there is no combinational path from in_valid/out_ready to any output.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand beat handshake
//   in_data, in_sub      : operand and operation (OP_SUB subtracts)
//   in_last              : final beat of the frame
//   out_valid/out_ready  : frame result handshake
//   out_data             : frame sum
//   out_ovf              : sticky overflow over the frame
//   out_count            : beats in frame, saturating at 2^CW-1
//
// Build option: define ADDSUB_ACC_SATURATE_EN to clamp the running sum on
// overflow instead of wrapping.
// ---------------------------------------------------------------------------
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sub,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_ovf,
    output logic [CW-1:0] out_count
);

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;

    logic [W-1:0]  sum_r;
    logic          sum_ovf;
    logic [W-1:0]  acc_load;
    logic          accept;
    logic          handshake;

    AddSub #(.W(W)) u_addsub (
        .A   (acc_q),
        .B   (in_data),
        .c0  (in_sub),
        .R   (sum_r),
        .ovf (sum_ovf)
    );

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam logic [W-1:0] SAT_POS = W'(MAX_POS(W));
    localparam logic [W-1:0] SAT_NEG = W'(MAX_NEG(W));

    // A wrapped result with the sign bit set came from a positive overflow.
    always_comb begin
        acc_load = sum_r;
        if (sum_ovf) begin
            acc_load = sum_r[W-1] ? SAT_POS : SAT_NEG;
        end
    end
`else
    always_comb begin
        acc_load = sum_r;
    end
`endif

    assign accept    = in_valid & (state_q == ACCUM);
    assign handshake = out_ready & (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (accept) begin
            acc_d = acc_load;
            ovf_d = ovf_q | sum_ovf;
            if (count_q != {CW{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
            if (in_last) begin
                state_d = HOLD;
            end
        end
        // Result taken: clear so the next frame starts from zero.
        if (handshake) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
module tb_addsub_accumulator;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready2;
  logic [15:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_valid2;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_data2;
  logic        out_ovf;
  logic        out_ovf2;
  logic [7:0]  out_count;
  logic [1:0]  out_count2;

  int compared;
  int mismatched;

  // reference model: signed integer sum plus flags
  int acc_m;
  bit ovf_m;
  int cnt_m;
  int cnt2_m;

  addsub_accumulator #(.W(16), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count)
  );

  // narrow beat counter instance sharing the same stimulus
  addsub_accumulator #(.W(16), .CW(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_ovf(out_ovf2), .out_count(out_count2)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    acc_m  = 0;
    ovf_m  = 1'b0;
    cnt_m  = 0;
    cnt2_m = 0;
  endfunction

  function automatic void model_beat(input logic [15:0] d, input logic s);
    int dv;
    int exact;
    dv    = int'($signed(d));
    exact = s ? (acc_m - dv) : (acc_m + dv);
    if (exact > 32767 || exact < -32768) begin
      ovf_m = 1'b1;
`ifdef ADDSUB_ACC_SATURATE_EN
      exact = (exact > 32767) ? 32767 : -32768;
`else
      exact = ((exact + 98304) % 65536) - 32768;
`endif
    end
    acc_m = exact;
    if (cnt_m < 255) cnt_m++;
    if (cnt2_m < 3) cnt2_m++;
  endfunction

  // driver: present one beat, wait (bounded) until it is accepted
  task automatic send_beat(input logic [15:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("beat_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(d, s);
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] exp_d;
    exp_d = 16'(acc_m);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_out_ovf"}, 32'(out_ovf), 32'(ovf_m));
    chk({tag, "_out_count"}, 32'(out_count), 32'(cnt_m));
    chk({tag, "_out_data_cw2"}, 32'(out_data2), 32'(exp_d));
    chk({tag, "_out_count_cw2"}, 32'(out_count2), 32'(cnt2_m));
  endtask

  // called one cycle after the last beat: check, stall, then take the result
  task automatic finish_frame(input string tag, input int stall);
    check_outputs(tag);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_outputs({tag, "_stall"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    model_clear();
  endtask

  initial begin
    int len;
    logic [15:0] d;
    logic s;
    compared   = 0;
    mismatched = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);

    // add 5, add 7, subtract 3 -> 9, checked on the cycle after the last beat
    send_beat(16'd5, 1'b0, 1'b0);
    send_beat(16'd7, 1'b0, 1'b0);
    send_beat(16'd3, 1'b1, 1'b1);
    chk("basic_out_data_const", 32'(out_data), 32'd9);
    finish_frame("basic", 0);

    // positive overflow
    send_beat(16'h7000, 1'b0, 1'b0);
    send_beat(16'h2000, 1'b0, 1'b1);
`ifdef ADDSUB_ACC_SATURATE_EN
    chk("povf_out_data_const", 32'(out_data), 32'h7FFF);
`else
    chk("povf_out_data_const", 32'(out_data), 32'h9000);
`endif
    chk("povf_out_ovf_const", 32'(out_ovf), 32'd1);
    finish_frame("povf", 1);

    // single-beat subtract of the most negative value
    send_beat(16'h8000, 1'b1, 1'b1);
`ifdef ADDSUB_ACC_SATURATE_EN
    chk("sub8000_out_data_const", 32'(out_data), 32'h7FFF);
`else
    chk("sub8000_out_data_const", 32'(out_data), 32'h8000);
`endif
    finish_frame("sub8000", 0);

    // back-pressure with the next frame's first beat waiting
    send_beat(16'd100, 1'b0, 1'b0);
    send_beat(16'd40, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'd4;
    in_sub   = 1'b0;
    in_last  = 1'b0;
    finish_frame("bp", 5);
    send_beat(16'd4, 1'b0, 1'b0);
    send_beat(16'd2, 1'b0, 1'b1);
    chk("bp_next_out_data_const", 32'(out_data), 32'd6);
    finish_frame("bp_next", 0);

    // reset mid-frame discards the frame
    send_beat(16'd11, 1'b0, 1'b0);
    send_beat(16'd22, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    send_beat(16'd1, 1'b0, 1'b1);
    chk("midrst_next_out_count_const", 32'(out_count), 32'd1);
    finish_frame("midrst_next", 0);

    // reset while holding a result
    send_beat(16'd9, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    chk("holdrst_out_valid", 32'(out_valid), 32'd0);
    chk("holdrst_in_ready", 32'(in_ready), 32'd1);

    // five beats of add 1: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) send_beat(16'd1, 1'b0, (i == 4));
    chk("sat5_out_count_cw2_const", 32'(out_count2), 32'd3);
    chk("sat5_out_data_const", 32'(out_data), 32'd5);
    finish_frame("sat5", 0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        d = 16'($urandom);
        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
        s = 1'($urandom_range(0, 1));
        send_beat(d, s, (b == len - 1));
      end
      finish_frame("rand", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
